// File: rtl/ahb_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// ahb_lite_mem_slave
//
// Parametrised AHB-Lite memory slave. It is a byte-addressed RAM with
// little-endian byte lanes, a selectable data width (32 or 64) and depth, and
// a programmable number of wait states per OKAY data phase. The address and
// data phases are pipelined. Illegal accesses receive the two-cycle ERROR
// response.
//
// Optional feature macro: AHB_MEM_ROM_REGION_EN
//   When this macro is defined, any write below ROM_BYTES is illegal and gets
//   an ERROR response. Reads in that region are still OKAY.
//   When it is undefined, ROM_BYTES is ignored and the whole memory is
//   writable.
//
// Ports:
//   HCLK       in   bus clock
//   HRESET     in   asynchronous active-high reset
//   HSEL       in   slave select from the decoder
//   HADDR      in   byte address (ADDR_WIDTH bits)
//   HWRITE     in   1 = write, 0 = read
//   HSIZE      in   transfer size, 2^HSIZE bytes
//   HTRANS     in   IDLE/BUSY/NONSEQ/SEQ
//   HBURST     in   burst type; ignored because every beat carries its address
//   HREADY     in   bus-wide ready from the read-data MUX
//   HWDATA     in   write data, valid in the data phase
//   HREADYOUT  out  slave ready
//   HRESP      out  0 = OKAY, 1 = ERROR
//   HRDATA     out  read data; zero outside a read data phase
// ---------------------------------------------------------------------------
module ahb_lite_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0,
    parameter int ROM_BYTES   = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic                  HREADY,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int NB      = DATA_WIDTH / 8;
    localparam int LANE_AW = $clog2(NB);
    localparam int MEM_AW  = $clog2(MEM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic                hreadyout_q, hreadyout_d;
    logic                hresp_q, hresp_d;

    logic [7:0]          mem [MEM_BYTES];

    logic                accept;
    logic                out_of_range;
    logic                bad_size;
    logic                misaligned;
    logic                rom_write;
    logic                illegal;
    logic [2:0]          align_mask;
    logic [NB-1:0]       lane_en;
    logic [DATA_WIDTH-1:0] hrdata;
    logic [MEM_AW-LANE_AW-1:0] line_q;
    logic [LANE_AW-1:0]  lane_off_q;
    logic                unused_ok;

    // HBURST and HTRANS[0] are not needed, because every beat is self-addressed.
    // The XOR below keeps these inputs visibly consumed.
`ifdef AHB_MEM_ROM_REGION_EN
    assign unused_ok = ^{HBURST, HTRANS[0]};
`else
    assign unused_ok = ^{HBURST, HTRANS[0], (ROM_BYTES > 0)};
`endif

    // Address-phase decode: detect an accepted transfer and classify it as
    // legal or illegal. Because MEM_BYTES is a power of two, the range check
    // reduces to testing the upper address bits.
    always_comb begin
        accept       = HSEL & HREADY & HTRANS[1];
        out_of_range = |HADDR[ADDR_WIDTH-1:MEM_AW];
        bad_size     = (HSIZE > 3'(LANE_AW));
        case (HSIZE)
            3'd0:    align_mask = 3'b000;
            3'd1:    align_mask = 3'b001;
            3'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
        misaligned = |(HADDR[2:0] & align_mask);
`ifdef AHB_MEM_ROM_REGION_EN
        rom_write = HWRITE && (HADDR < ADDR_WIDTH'(ROM_BYTES));
`else
        rom_write = 1'b0;
`endif
        illegal = out_of_range | bad_size | misaligned | rom_write;
    end

    // Next-state logic. New transfers are accepted only in states where this
    // slave drives HREADYOUT high (IDLE, DATA, ERR2). In WAIT and ERR1 the bus
    // is stalled, so the address-phase inputs are ignored there. The ready and
    // response values are derived from the next state, so both outputs come
    // straight from flops.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                if (accept) begin
                    addr_d  = HADDR[MEM_AW-1:0];
                    write_d = HWRITE;
                    size_d  = HSIZE;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    // Controller registers. Asserting reset mid-transfer returns the slave to
    // IDLE, which also drops any pending write.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            size_q      <= size_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    assign line_q     = addr_q[MEM_AW-1:LANE_AW];
    assign lane_off_q = addr_q[LANE_AW-1:0];

    // Active byte lanes for the registered transfer: 2^size lanes, starting
    // at the lane selected by the low address bits.
    always_comb begin
        lane_en = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(lane_off_q)) && (i < int'(lane_off_q) + (1 << size_q))) begin
                lane_en[i] = 1'b1;
            end
        end
    end

    // Memory array. A write commits at the edge that ends its DATA cycle, so a
    // read data phase that immediately follows sees the new bytes. The array
    // is deliberately not reset.
    always_ff @(posedge HCLK) begin
        if ((state_q == ST_DATA) && write_q) begin
            for (int i = 0; i < NB; i++) begin
                if (lane_en[i]) begin
                    mem[{line_q, LANE_AW'(i)}] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    // Read data comes straight from the array during a read DATA cycle.
    // Lanes outside the transfer, and every other state, return zero.
    always_comb begin
        hrdata = '0;
        if ((state_q == ST_DATA) && !write_q) begin
            for (int i = 0; i < NB; i++) begin
                if (lane_en[i]) begin
                    hrdata[8*i +: 8] = mem[{line_q, LANE_AW'(i)}];
                end
            end
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_lite_mem_slave
//
// Self-checking bench for ahb_lite_mem_slave, built with three wait states
// and a 512-byte memory. A byte-array reference model tracks memory contents
// and applies the legality rules directly. A pipelined driver feeds queued
// transfers onto the bus and checks every cycle against that model.
// ---------------------------------------------------------------------------
module tb_ahb_lite_mem_slave;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int NB   = DW / 8;
   localparam int MEMB = 512;
   localparam int WS   = 3;
   localparam int ROMB = 256;
`ifdef AHB_MEM_ROM_REGION_EN
   localparam bit          ROM_EN = 1'b1;
   localparam int unsigned TBASE  = 256;
`else
   localparam bit          ROM_EN = 1'b0;
   localparam int unsigned TBASE  = 0;
`endif

   logic          HCLK   = 1'b0;
   logic          HRESET = 1'b1;
   logic          HSEL   = 1'b0;
   logic [AW-1:0] HADDR  = '0;
   logic          HWRITE = 1'b0;
   logic [2:0]    HSIZE  = 3'd0;
   logic [1:0]    HTRANS = 2'b00;
   logic [2:0]    HBURST = 3'd0;
   logic [DW-1:0] HWDATA = '0;
   logic          hreadyout;
   logic          hresp;
   logic [DW-1:0] hrdata;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit          wr;
      int unsigned addr;
      int          sz;
      logic [31:0] data;
   } xfer_t;

   xfer_t       xq[$];
   logic [31:0] last_rd;
   bit          gaps_en = 1'b0;

   logic [7:0] mdl_mem [MEMB];
   bit         known   [MEMB];

   always #5 HCLK = ~HCLK;

   ahb_lite_mem_slave #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_BYTES  (MEMB),
      .WAIT_STATES(WS),
      .ROM_BYTES  (ROMB)
   ) dut (
      .HCLK     (HCLK),
      .HRESET   (HRESET),
      .HSEL     (HSEL),
      .HADDR    (HADDR),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HTRANS   (HTRANS),
      .HBURST   (HBURST),
      .HREADY   (hreadyout),
      .HWDATA   (HWDATA),
      .HREADYOUT(hreadyout),
      .HRESP    (hresp),
      .HRDATA   (hrdata)
   );

   // One comparison: count it, and on a mismatch count the failure and report it.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Legality rules of the slave, stated directly.
   function automatic bit isIllegal(input bit wr, input int unsigned addr, input int sz);
      int unsigned nbytes;
      nbytes = 32'(1) << sz;
      if (addr >= MEMB) return 1'b1;
      if (nbytes > NB) return 1'b1;
      if ((addr % nbytes) != 0) return 1'b1;
      if (ROM_EN && wr && (addr < ROMB)) return 1'b1;
      return 1'b0;
   endfunction

   // Expected read word. The mask covers only bytes whose contents are known.
   function automatic void expectRead(input int unsigned addr, input int sz,
                                      output logic [31:0] exp, output logic [31:0] mask);
      exp  = '0;
      mask = '1;
      for (int b = 0; b < (1 << sz); b++) begin
         int unsigned a;
         int          lane;
         a    = addr + 32'(b);
         lane = int'(a % NB);
         exp[8*lane +: 8] = mdl_mem[a];
         if (!known[a]) mask[8*lane +: 8] = 8'h00;
      end
   endfunction

   function automatic void modelWrite(input int unsigned addr, input int sz, input logic [31:0] data);
      for (int b = 0; b < (1 << sz); b++) begin
         int unsigned a;
         int          lane;
         a    = addr + 32'(b);
         lane = int'(a % NB);
         mdl_mem[a] = data[8*lane +: 8];
         known[a]   = 1'b1;
      end
   endfunction

   task automatic push(input bit wr, input int unsigned addr, input int sz, input logic [31:0] data);
      xfer_t t;
      t.wr   = wr;
      t.addr = addr;
      t.sz   = sz;
      t.data = data;
      xq.push_back(t);
   endtask

   // Pipelined driver. It is entered one time unit after a rising edge.
   // Each loop pass drives one address phase (the next queued transfer, or
   // an idle/unselected cycle) plus the data phase of the outstanding
   // transfer, then checks the outputs at the falling edge.
   task automatic applyStimulus();
      int          n;
      int          ai;
      int          di;
      int          low;
      int          cyc;
      bit          rdy;
      bit          done;
      bit          ill;
      bit          gap;
      logic [31:0] exp;
      logic [31:0] mask;
      n    = xq.size();
      ai   = 0;
      di   = -1;
      low  = 0;
      cyc  = 0;
      done = 1'b0;
      while ((cyc < 20 * (n + 2)) && !done) begin
         gap = (ai < n) && gaps_en && ($urandom_range(0, 4) == 0);
         if ((ai < n) && !gap) begin
            HSEL   = 1'b1;
            HTRANS = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
            HWRITE = xq[ai].wr;
            HADDR  = xq[ai].addr;
            HSIZE  = 3'(xq[ai].sz);
            HBURST = 3'($urandom_range(0, 7));
         end else if (gap) begin
            case ($urandom_range(0, 2))
               0:       begin HSEL = 1'b1; HTRANS = 2'b00; end
               1:       begin HSEL = 1'b1; HTRANS = 2'b01; end
               default: begin HSEL = 1'b0; HTRANS = 2'b10; end
            endcase
            HADDR = 32'($urandom_range(0, MEMB - 1));
         end else begin
            HSEL   = 1'b0;
            HTRANS = 2'b00;
         end
         HWDATA = (di >= 0) ? xq[di].data : 32'h0;

         @(negedge HCLK);
         rdy = hreadyout;
         if (di < 0) begin
            checkOutput("idle_ready", hreadyout, 1);
            checkOutput("idle_resp", hresp, 0);
            checkOutput("idle_rdata", hrdata, 0);
         end else begin
            ill = isIllegal(xq[di].wr, xq[di].addr, xq[di].sz);
            if (!rdy) begin
               low++;
               checkOutput("stall_resp", hresp, ill);
               if (!ill) checkOutput("stall_rdata", hrdata, 0);
            end else begin
               checkOutput("final_resp", hresp, ill);
               checkOutput("low_cycles", low, ill ? 1 : WS);
               if (ill) begin
                  checkOutput("err_rdata", hrdata, 0);
               end else if (!xq[di].wr) begin
                  expectRead(xq[di].addr, xq[di].sz, exp, mask);
                  last_rd = hrdata;
                  checkOutput("rdata", hrdata & mask, exp & mask);
               end else begin
                  modelWrite(xq[di].addr, xq[di].sz, xq[di].data);
               end
            end
         end

         @(posedge HCLK);
         #1;
         if (rdy) begin
            if ((ai < n) && !gap) begin
               di = ai;
               ai++;
            end else begin
               di = -1;
            end
            low = 0;
         end
         if ((ai >= n) && (di < 0)) done = 1'b1;
         cyc++;
      end
      total++;
      assert (done) else begin
         bad++;
         $error("[TB] FAIL timeout observed=%0d_pending expected=0_pending", n - ai + ((di >= 0) ? 1 : 0));
      end
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      xq.delete();
   endtask

   initial begin
      // Reset state.
      repeat (2) @(posedge HCLK);
      #1;
      checkOutput("reset_ready", hreadyout, 1);
      checkOutput("reset_resp", hresp, 0);
      checkOutput("reset_rdata", hrdata, 0);
      @(negedge HCLK);
      HRESET = 1'b0;
      @(posedge HCLK);
      #1;

      // Fill every writable word with random data so that later reads are fully checked.
      for (int a = (ROM_EN ? ROMB : 0); a < MEMB; a += 4) begin
         push(1'b1, 32'(a), 2, $urandom);
      end
      applyStimulus();
      $display("[TB] memory initialised");

      // Word write followed by a back-to-back read of the same address.
      push(1'b1, TBASE + 32'h10, 2, 32'hDEADBEEF);
      push(1'b0, TBASE + 32'h10, 2, 32'h0);
      applyStimulus();
      checkOutput("t1_word", last_rd, 32'hDEADBEEF);

      // Byte writes must land only in their own lanes.
      push(1'b1, TBASE + 32'h20, 2, 32'h0);
      push(1'b1, TBASE + 32'h21, 0, 32'hABCD11EF);
      push(1'b1, TBASE + 32'h23, 0, 32'h22998877);
      push(1'b0, TBASE + 32'h20, 2, 32'h0);
      applyStimulus();
      checkOutput("t2_bytes", last_rd, 32'h22001100);

      // Illegal accesses (out of range, misaligned, oversize), then a legal read.
      push(1'b0, MEMB, 2, 32'h0);
      push(1'b0, TBASE + 32'h01, 1, 32'h0);
      push(1'b1, TBASE + 32'h00, 3, 32'h0);
      push(1'b0, TBASE + 32'h10, 2, 32'h0);
      applyStimulus();
      checkOutput("t4_after_err", last_rd, 32'hDEADBEEF);

`ifdef AHB_MEM_ROM_REGION_EN
      // Protected region: a write at 0x80 is refused, and a write at 0x100 is accepted.
      push(1'b1, 32'h80, 2, 32'h01020304);
      push(1'b0, 32'h80, 2, 32'h0);
      push(1'b1, 32'h100, 2, 32'hCAFEF00D);
      push(1'b0, 32'h100, 2, 32'h0);
      applyStimulus();
      checkOutput("t5_rom_ok", last_rd, 32'hCAFEF00D);
`endif

      // Randomised mix, including idle, busy and unselected cycles between transfers.
      gaps_en = 1'b1;
      for (int k = 0; k < 150; k++) begin
         int          sz;
         int unsigned a;
         sz = $urandom_range(0, 3);
         case ($urandom_range(0, 9))
            0:       a = 32'(MEMB) + 32'($urandom_range(0, 255));
            1:       a = 32'($urandom_range(0, MEMB - 1));
            default: a = 32'($urandom_range(0, MEMB - 1)) & ~32'((1 << sz) - 1);
         endcase
         push(1'($urandom_range(0, 1)), a, sz, $urandom);
      end
      applyStimulus();
      gaps_en = 1'b0;

      // Assert reset during the wait states of a write: the write must be dropped.
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b1;
      HADDR  = TBASE + 32'h40;
      HSIZE  = 3'd2;
      @(posedge HCLK);
      #1;
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWDATA = 32'h5A5AA5A5;
      @(posedge HCLK);
      #1;
      checkOutput("t6_in_wait", hreadyout, 0);
      HRESET = 1'b1;
      #1;
      checkOutput("t6_rst_ready", hreadyout, 1);
      checkOutput("t6_rst_resp", hresp, 0);
      checkOutput("t6_rst_rdata", hrdata, 0);
      @(negedge HCLK);
      HRESET = 1'b0;
      @(posedge HCLK);
      #1;
      push(1'b0, TBASE + 32'h40, 2, 32'h0);
      applyStimulus();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
